// File: rtl/instr_register_pipe.sv
// instr_register_pipe
// ---------------------------------------------------------------------------
// Pipelined instruction register file. Each loaded instruction (opcode plus
// two signed operands) is captured in stage 1. On the following edge stage 2
// computes the full-width result and writes the word into the addressed
// entry. A registered read port returns the stored word with a one-cycle
// valid strobe.
//
// Optional feature macro: INSTR_REG_BYPASS_EN
//   When defined, a read sampled on the same edge as a stage-2 write to the
//   same pointer returns the word being written. When undefined, such a read
//   returns the old contents.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous active-high reset
//   load_en        capture {opcode, operand_a, operand_b, write_pointer}
//   opcode         operation (opcode_t)
//   operand_a/b    signed OPERAND_W operands
//   write_pointer  target entry of the load
//   read_en        read request; rd_* update on this edge
//   read_pointer   entry to read
//   rd_valid       one-cycle pulse, high the cycle after a read request
//   rd_opcode      stored opcode
//   rd_operand_a/b stored operands
//   rd_result      stored 2*OPERAND_W signed result
//   rd_entry_valid entry has been written since reset
//   rd_div0        stored DIV/MOD had operand_b == 0
//   valid_count    number of entries written since reset
//
// Handshake: this block has no back-pressure. load_en and read_en are
// accepted on every edge where reset is low. rd_valid is a single-cycle
// pulse, and rd_* hold their last value while rd_valid is low.
// ---------------------------------------------------------------------------
package instr_register_pkg;
   typedef enum logic [2:0] {
      ZERO  = 3'd0,
      PASSA = 3'd1,
      PASSB = 3'd2,
      ADD   = 3'd3,
      SUB   = 3'd4,
      MULT  = 3'd5,
      DIV   = 3'd6,
      MOD   = 3'd7
   } opcode_t;
endpackage

module instr_register_pipe
   import instr_register_pkg::*;
#(
   parameter  int DEPTH     = 32,
   parameter  int OPERAND_W = 32,
   localparam int ADDR_W    = $clog2(DEPTH)
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            load_en,
   input  opcode_t                         opcode,
   input  logic signed [OPERAND_W-1:0]     operand_a,
   input  logic signed [OPERAND_W-1:0]     operand_b,
   input  logic        [ADDR_W-1:0]        write_pointer,
   input  logic                            read_en,
   input  logic        [ADDR_W-1:0]        read_pointer,
   output logic                            rd_valid,
   output opcode_t                         rd_opcode,
   output logic signed [OPERAND_W-1:0]     rd_operand_a,
   output logic signed [OPERAND_W-1:0]     rd_operand_b,
   output logic signed [2*OPERAND_W-1:0]   rd_result,
   output logic                            rd_entry_valid,
   output logic                            rd_div0,
   output logic        [ADDR_W:0]          valid_count
);

   localparam int RW = 2 * OPERAND_W;
   localparam logic [ADDR_W:0] COUNT_ONE = 1;

   // Stage-1 registers
   logic                         s1_pending;
   opcode_t                      s1_opcode;
   logic signed [OPERAND_W-1:0]  s1_a;
   logic signed [OPERAND_W-1:0]  s1_b;
   logic        [ADDR_W-1:0]     s1_ptr;

   // Storage
   opcode_t                      mem_opcode [DEPTH];
   logic signed [OPERAND_W-1:0]  mem_a      [DEPTH];
   logic signed [OPERAND_W-1:0]  mem_b      [DEPTH];
   logic signed [RW-1:0]         mem_result [DEPTH];
   logic        [DEPTH-1:0]      mem_div0;
   logic        [DEPTH-1:0]      entry_valid;

   // Stage-2 compute
   logic signed [RW-1:0]         a_ext;
   logic signed [RW-1:0]         b_ext;
   logic signed [RW-1:0]         s2_result;
   logic                         s2_div0;
   logic                         fwd;

   // Operating at 2W keeps MULT exact. It also keeps the most-negative / -1
   // DIV case representable as +2^(W-1).
   assign a_ext = {{OPERAND_W{s1_a[OPERAND_W-1]}}, s1_a};
   assign b_ext = {{OPERAND_W{s1_b[OPERAND_W-1]}}, s1_b};

   always_comb begin
      s2_result = '0;
      s2_div0   = 1'b0;
      case (s1_opcode)
         ZERO:  s2_result = '0;
         PASSA: s2_result = a_ext;
         PASSB: s2_result = b_ext;
         ADD:   s2_result = a_ext + b_ext;
         SUB:   s2_result = a_ext - b_ext;
         MULT:  s2_result = a_ext * b_ext;
         // Signed / truncates toward zero, and % takes the sign of the dividend.
         DIV: begin
            if (b_ext == '0) s2_div0 = 1'b1;
            else             s2_result = a_ext / b_ext;
         end
         MOD: begin
            if (b_ext == '0) s2_div0 = 1'b1;
            else             s2_result = a_ext % b_ext;
         end
         default: s2_result = '0;
      endcase
   end

`ifdef INSTR_REG_BYPASS_EN
   assign fwd = s1_pending && (s1_ptr == read_pointer);
`else
   assign fwd = 1'b0;
`endif

   // Stage 1 capture
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_pending <= 1'b0;
         s1_opcode  <= ZERO;
         s1_a       <= '0;
         s1_b       <= '0;
         s1_ptr     <= '0;
      end else begin
         s1_pending <= load_en;
         if (load_en) begin
            s1_opcode <= opcode;
            s1_a      <= operand_a;
            s1_b      <= operand_b;
            s1_ptr    <= write_pointer;
         end
      end
   end

   // Stage 2 write and occupancy tracking
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_opcode[i] <= ZERO;
            mem_a[i]      <= '0;
            mem_b[i]      <= '0;
            mem_result[i] <= '0;
         end
         mem_div0    <= '0;
         entry_valid <= '0;
         valid_count <= '0;
      end else if (s1_pending) begin
         mem_opcode[s1_ptr]  <= s1_opcode;
         mem_a[s1_ptr]       <= s1_a;
         mem_b[s1_ptr]       <= s1_b;
         mem_result[s1_ptr]  <= s2_result;
         mem_div0[s1_ptr]    <= s2_div0;
         entry_valid[s1_ptr] <= 1'b1;
         // Only first writes count, so the count tops out at DEPTH.
         if (!entry_valid[s1_ptr]) valid_count <= valid_count + COUNT_ONE;
      end
   end

   // Registered read port
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_valid       <= 1'b0;
         rd_opcode      <= ZERO;
         rd_operand_a   <= '0;
         rd_operand_b   <= '0;
         rd_result      <= '0;
         rd_entry_valid <= 1'b0;
         rd_div0        <= 1'b0;
      end else begin
         rd_valid <= read_en;
         if (read_en) begin
            if (fwd) begin
               rd_opcode      <= s1_opcode;
               rd_operand_a   <= s1_a;
               rd_operand_b   <= s1_b;
               rd_result      <= s2_result;
               rd_entry_valid <= 1'b1;
               rd_div0        <= s2_div0;
            end else begin
               rd_opcode      <= mem_opcode[read_pointer];
               rd_operand_a   <= mem_a[read_pointer];
               rd_operand_b   <= mem_b[read_pointer];
               rd_result      <= mem_result[read_pointer];
               rd_entry_valid <= entry_valid[read_pointer];
               rd_div0        <= mem_div0[read_pointer];
            end
         end
      end
   end

endmodule

// File: tb/tb_instr_register_pipe.sv
// Self-checking bench for instr_register_pipe (DEPTH=32, OPERAND_W=32).
module tb_instr_register_pipe;
   import instr_register_pkg::*;

   localparam int DEPTH  = 32;
   localparam int W      = 32;
   localparam int ADDR_W = $clog2(DEPTH);

   typedef struct packed {
      logic          ev;
      opcode_t       op;
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [2*W-1:0] r;
      logic          d0;
   } exp_t;

   // ---------------- clock / reset ----------------
   logic                 clk = 1'b0;
   logic                 reset;
   logic                 load_en;
   opcode_t              opcode;
   logic signed [W-1:0]  operand_a, operand_b;
   logic [ADDR_W-1:0]    write_pointer, read_pointer;
   logic                 read_en;
   logic                 rd_valid;
   opcode_t              rd_opcode;
   logic signed [W-1:0]  rd_operand_a, rd_operand_b;
   logic signed [2*W-1:0] rd_result;
   logic                 rd_entry_valid, rd_div0;
   logic [ADDR_W:0]      valid_count;

   always #5 clk = ~clk;

   instr_register_pipe #(.DEPTH(DEPTH), .OPERAND_W(W)) dut (
      .clk(clk), .reset(reset), .load_en(load_en), .opcode(opcode),
      .operand_a(operand_a), .operand_b(operand_b), .write_pointer(write_pointer),
      .read_en(read_en), .read_pointer(read_pointer), .rd_valid(rd_valid),
      .rd_opcode(rd_opcode), .rd_operand_a(rd_operand_a), .rd_operand_b(rd_operand_b),
      .rd_result(rd_result), .rd_entry_valid(rd_entry_valid), .rd_div0(rd_div0),
      .valid_count(valid_count)
   );

   // ---------------- scoreboard state ----------------
   exp_t exp_q[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   function automatic exp_t mk(input logic ev, input opcode_t op, input int a,
                               input int b, input longint r, input logic d0);
      exp_t e;
      e.ev = ev; e.op = op; e.a = a; e.b = b; e.r = r; e.d0 = d0;
      return e;
   endfunction

   function automatic exp_t got_word();
      exp_t g;
      g.ev = rd_entry_valid; g.op = rd_opcode; g.a = rd_operand_a;
      g.b = rd_operand_b; g.r = rd_result; g.d0 = rd_div0;
      return g;
   endfunction

   task automatic check(input string name, input longint act, input longint req);
      n_vec++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic ld, input opcode_t op, input int a, input int b,
                        input int wp, input logic rd, input int rp, input exp_t e);
      @(negedge clk);
      load_en       = ld;
      opcode        = op;
      operand_a     = a;
      operand_b     = b;
      write_pointer = ADDR_W'(wp);
      read_en       = rd;
      read_pointer  = ADDR_W'(rp);
      if (rd) exp_q.push_back(e);
   endtask

   task automatic idle();
      drive(1'b0, ZERO, 0, 0, 0, 1'b0, 0, '0);
   endtask

   task automatic load(input opcode_t op, input int a, input int b, input int wp);
      drive(1'b1, op, a, b, wp, 1'b0, 0, '0);
   endtask

   task automatic read(input int rp, input exp_t e);
      drive(1'b0, ZERO, 0, 0, 0, 1'b1, rp, e);
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rd_valid) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_rd_valid: got rd_valid=1 expected no read pending");
         end else begin
            exp_t e, g;
            e = exp_q.pop_front();
            g = got_word();
            n_vec++;
            if (g !== e) begin
               n_fail++;
               $display("FAIL read: got ev=%0b op=%s a=%0h b=%0h r=%0h d0=%0b expected ev=%0b op=%s a=%0h b=%0h r=%0h d0=%0b",
                        g.ev, g.op.name(), g.a, g.b, g.r, g.d0,
                        e.ev, e.op.name(), e.a, e.b, e.r, e.d0);
            end
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   exp_t blank;

   initial begin
      blank = mk(1'b0, ZERO, 0, 0, 0, 1'b0);
      reset = 1'b1; load_en = 1'b0; read_en = 1'b0; opcode = ZERO;
      operand_a = '0; operand_b = '0; write_pointer = '0; read_pointer = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Reset state
      check("reset_rd_valid", longint'(rd_valid), 0);
      check("reset_valid_count", longint'(valid_count), 0);
      check("reset_rd_result", rd_result, 0);
      check("reset_rd_opcode", longint'(rd_opcode), longint'(ZERO));

      // Reads of never-written entries
      read(0, blank);
      read(DEPTH - 1, blank);
      idle();
      check("count_empty", longint'(valid_count), 0);

      // ADD, then overwrite the same entry with MULT
      load(ADD, 7, -3, 5);
      idle();
      read(5, mk(1'b1, ADD, 7, -3, 64'sd4, 1'b0));
      check("count_after_add", longint'(valid_count), 1);
      load(MULT, -4, 6, 5);
      idle();
      read(5, mk(1'b1, MULT, -4, 6, -64'sd24, 1'b0));
      check("count_after_rewrite", longint'(valid_count), 1);

      // Arithmetic corner cases, loaded back to back
      load(MULT, 32'h7FFFFFFF, 32'h7FFFFFFF, 6);
      load(DIV, 32'h80000000, -1, 7);
      load(MOD, -7, 2, 8);
      load(DIV, 9, 0, 9);
      load(MOD, 9, 0, 10);
      load(SUB, 3, 10, 11);
      load(PASSA, -5, 4, 12);
      load(PASSB, 1, 9, 13);
      load(ZERO, 1, 2, 14);
      load(ADD, 1, 1, 15);
      load(ADD, 2, 2, 15);
      idle();
      read(6,  mk(1'b1, MULT, 32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF00000001, 1'b0));
      read(7,  mk(1'b1, DIV, 32'h80000000, -1, 64'h0000000080000000, 1'b0));
      read(8,  mk(1'b1, MOD, -7, 2, -64'sd1, 1'b0));
      read(9,  mk(1'b1, DIV, 9, 0, 0, 1'b1));
      read(10, mk(1'b1, MOD, 9, 0, 0, 1'b1));
      read(11, mk(1'b1, SUB, 3, 10, -64'sd7, 1'b0));
      read(12, mk(1'b1, PASSA, -5, 4, -64'sd5, 1'b0));
      read(13, mk(1'b1, PASSB, 1, 9, 64'sd9, 1'b0));
      read(14, mk(1'b1, ZERO, 1, 2, 0, 1'b0));
      read(15, mk(1'b1, ADD, 2, 2, 64'sd4, 1'b0));
      check("count_after_batch", longint'(valid_count), 11);

      // Read on the same edge as the stage-2 write
      load(ADD, 1, 2, 3);
`ifdef INSTR_REG_BYPASS_EN
      read(3, mk(1'b1, ADD, 1, 2, 64'sd3, 1'b0));
`else
      read(3, blank);
`endif
      idle();
      read(3, mk(1'b1, ADD, 1, 2, 64'sd3, 1'b0));

      // Read while the entry is still in stage 1
      drive(1'b1, ADD, 5, 5, 4, 1'b1, 4, blank);
      idle();
      read(4, mk(1'b1, ADD, 5, 5, 64'sd10, 1'b0));
      check("count_after_bypass", longint'(valid_count), 13);

      // Reset while an instruction sits in stage 1, with load/read held high
      load(ADD, 8, 8, 2);
      @(negedge clk);
      reset = 1'b1; load_en = 1'b1; read_en = 1'b1; write_pointer = ADDR_W'(2);
      @(negedge clk);
      reset = 1'b0; load_en = 1'b0; read_en = 1'b0;
      check("reset_mid_count", longint'(valid_count), 0);
      read(2, blank);
      read(5, blank);
      idle();
      check("count_after_reset", longint'(valid_count), 0);

      // Fill every entry
      for (int i = 0; i < DEPTH; i++) load(ADD, i, i, i);
      idle();
      idle();
      check("count_full", longint'(valid_count), DEPTH);
      read(0,  mk(1'b1, ADD, 0, 0, 64'sd0, 1'b0));
      read(31, mk(1'b1, ADD, 31, 31, 64'sd62, 1'b0));
      read(17, mk(1'b1, ADD, 17, 17, 64'sd34, 1'b0));
      load(SUB, 1, 2, 17);
      idle();
      read(17, mk(1'b1, SUB, 1, 2, -64'sd1, 1'b0));
      check("count_full_rewrite", longint'(valid_count), DEPTH);

      repeat (4) idle();
      check("reads_outstanding", longint'(exp_q.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
